// File: rtl/mca_output_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mca_output_fifo
// Description : Tracks the multi-cycle adder schedule, captures its result
//               when valid, scales it (arithmetic shift + saturation) and
//               queues it in a small FIFO drained through a valid/ready port.
// Revision    : 1.0 - initial release
// ============================================================================
module mca_output_fifo #(
  parameter int WIDTH_COEFFICIENT = 32,
  parameter int WIDTH_OUT         = 16,
  parameter int SHIFT             = 8,
  parameter int DEPTH             = 4,
  parameter int ADD_CYCLES        = 16
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         enable,
  input  logic                         start,
  input  logic [WIDTH_COEFFICIENT-1:0] res,
  input  logic                         out_ready,
  input  logic                         clear_ovf,
  output logic [WIDTH_OUT-1:0]         out_data,
  output logic                         out_valid,
  output logic [$clog2(DEPTH):0]       level,
  output logic                         overflow
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_lvl_w = c_ptr_w + 1;

  localparam logic [4:0]         c_last = 5'(ADD_CYCLES - 1);
  localparam logic [c_lvl_w-1:0] c_full = c_lvl_w'(DEPTH);

  // Saturation bounds expressed at the width of the shifted result.
  localparam logic signed [WIDTH_COEFFICIENT-1:0] c_max =
    {{(WIDTH_COEFFICIENT-WIDTH_OUT+1){1'b0}}, {(WIDTH_OUT-1){1'b1}}};
  localparam logic signed [WIDTH_COEFFICIENT-1:0] c_min =
    {{(WIDTH_COEFFICIENT-WIDTH_OUT+1){1'b1}}, {(WIDTH_OUT-1){1'b0}}};

  typedef enum logic [1:0] {
    T_IDLE = 2'd0,
    T_WAIT = 2'd1,
    T_CAPT = 2'd2
  } state_t;

  state_t                        r_state;
  logic [4:0]                    r_cnt;
  logic [WIDTH_OUT-1:0]          r_mem [DEPTH];
  logic [c_ptr_w-1:0]            r_wptr;
  logic [c_ptr_w-1:0]            r_rptr;
  logic [c_lvl_w-1:0]            r_level;
  logic                          r_overflow;

  logic signed [WIDTH_COEFFICIENT-1:0] w_sh;
  logic [WIDTH_OUT-1:0]          w_scaled;
  logic                          w_push;
  logic                          w_pop;
  logic                          w_full;
  logic                          w_accept;
  logic                          w_drop;

  // Tracker mirrors the adder: idle, count ADD_CYCLES enabled edges, capture.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= T_IDLE;
      r_cnt   <= 5'd0;
    end else if (enable) begin
      case (r_state)
        T_IDLE: begin
          if (start) begin
            r_state <= T_WAIT;
            r_cnt   <= 5'd0;
          end
        end
        T_WAIT: begin
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == c_last) begin
            r_state <= T_CAPT;
          end
        end
        T_CAPT: begin
          // The adder samples start in its idle state on this same edge.
          if (start) begin
            r_state <= T_WAIT;
            r_cnt   <= 5'd0;
          end else begin
            r_state <= T_IDLE;
          end
        end
        default: r_state <= T_IDLE;
      endcase
    end
  end

  assign w_sh = $signed(res) >>> SHIFT;

  // Clamp the shifted result into the signed output range.
  always_comb begin
    w_scaled = w_sh[WIDTH_OUT-1:0];
    if (w_sh > c_max) begin
      w_scaled = {1'b0, {(WIDTH_OUT-1){1'b1}}};
    end else if (w_sh < c_min) begin
      w_scaled = {1'b1, {(WIDTH_OUT-1){1'b0}}};
    end
  end

  assign w_push   = enable && (r_state == T_CAPT);
  assign w_pop    = out_valid && out_ready;
  assign w_full   = (r_level == c_full);
  assign w_accept = w_push && (!w_full || w_pop);
  assign w_drop   = w_push && w_full && !w_pop;

  // Circular buffer storage, pointers and occupancy.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_accept) begin
        r_mem[r_wptr] <= w_scaled;
        r_wptr        <= r_wptr + c_ptr_w'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_ptr_w'(1);
      end
      if (w_accept && !w_pop) begin
        r_level <= r_level + c_lvl_w'(1);
      end else if (!w_accept && w_pop) begin
        r_level <= r_level - c_lvl_w'(1);
      end
    end
  end

  // Sticky drop flag; a drop in the same cycle outranks a clear request.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (clear_ovf) begin
      r_overflow <= 1'b0;
    end
  end

  assign out_data  = r_mem[r_rptr];
  assign out_valid = (r_level != '0);
  assign level     = r_level;
  assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_mca_output_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_mca_output_fifo
// Description : Self-checking bench for mca_output_fifo with a queue-based
//               reference model of the capture schedule and FIFO behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mca_output_fifo;

  localparam int WC    = 32;
  localparam int WO    = 16;
  localparam int SH    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          enable = 1'b0;
  logic          start = 1'b0;
  logic [WC-1:0] res = '0;
  logic          out_ready = 1'b0;
  logic          clear_ovf = 1'b0;
  logic [WO-1:0] out_data;
  logic          out_valid;
  logic [2:0]    level;
  logic          overflow;

  int n_cmp  = 0;
  int n_fail = 0;

  mca_output_fifo #(
    .WIDTH_COEFFICIENT(WC),
    .WIDTH_OUT(WO),
    .SHIFT(SH),
    .DEPTH(DEPTH),
    .ADD_CYCLES(16)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .enable(enable),
    .start(start),
    .res(res),
    .out_ready(out_ready),
    .clear_ovf(clear_ovf),
    .out_data(out_data),
    .out_valid(out_valid),
    .level(level),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Floor division by 2^SH, then clamp to the signed output range.
  function automatic logic [WO-1:0] scale(input logic [WC-1:0] r);
    longint v, d, s;
    v = longint'($signed(r));
    d = longint'(1) << SH;
    if (v >= 0) s = v / d;
    else        s = -((-v + d - 1) / d);
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return s[WO-1:0];
  endfunction

  // Reference model: a capture lands 17 enabled edges after start is seen.
  logic [WO-1:0] m_q[$];
  bit            m_ovf = 1'b0;
  int            m_phase = -1;
  bit            m_pop, m_push, m_drop;
  logic [WO-1:0] m_val;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_q.delete();
      m_ovf   = 1'b0;
      m_phase = -1;
    end else begin
      m_pop  = (m_q.size() > 0) && out_ready;
      m_push = 1'b0;
      m_val  = '0;
      if (enable) begin
        if (m_phase < 0) begin
          if (start) m_phase = 0;
        end else begin
          m_phase++;
          if (m_phase == 17) begin
            m_push  = 1'b1;
            m_val   = scale(res);
            m_phase = start ? 0 : -1;
          end
        end
      end
      if (m_pop) void'(m_q.pop_front());
      m_drop = m_push && (m_q.size() >= DEPTH);
      if (m_push && !m_drop) m_q.push_back(m_val);
      if (m_drop) m_ovf = 1'b1;
      else if (clear_ovf) m_ovf = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_run(input logic [WC-1:0] v);
    res   = v;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (17) tick();
  endtask

  task automatic drain();
    out_ready = 1'b1;
    repeat (DEPTH + 1) tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_cmp++; if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", level); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", overflow); end
    n_cmp++; if (out_data !== 16'h0000) begin n_fail++; $display("FAIL reset_data got %h want 0000", out_data); end
    resetn = 1'b1;
    enable = 1'b1;
    tick();
  endtask

  task automatic test_single();
    res   = 32'h0000_1234;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (16) tick();
    n_cmp++; if (level !== 3'd0) begin n_fail++; $display("FAIL single_early level got %0d want 0", level); end
    tick();
    n_cmp++; if (level !== 3'd1) begin n_fail++; $display("FAIL single_level got %0d want 1", level); end
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", out_valid); end
    n_cmp++; if (out_data !== 16'h0012) begin n_fail++; $display("FAIL single_data got %h want 0012", out_data); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL single_ovf got %b want 0", overflow); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_pop valid got %b want 0", out_valid); end
  endtask

  task automatic test_saturation();
    logic [WC-1:0] vin [4];
    logic [WO-1:0] vexp [4];
    logic [WC-1:0] r;
    vin[0] = 32'h7FFF_FFFF; vexp[0] = 16'h7FFF;
    vin[1] = 32'h8000_0000; vexp[1] = 16'h8000;
    vin[2] = 32'hFFFF_FF00; vexp[2] = 16'hFFFF;
    vin[3] = 32'hFFFF_FFFF; vexp[3] = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      do_run(vin[i]);
      n_cmp++;
      if (out_data !== vexp[i]) begin
        n_fail++; $display("FAIL sat_%0d res %h got %h want %h", i, vin[i], out_data, vexp[i]);
      end
      drain();
    end
    for (int i = 0; i < 8; i++) begin
      r = $urandom();
      if (i % 2 == 0) r = r >>> ($urandom_range(0, 16));
      do_run(r);
      n_cmp++;
      if (out_data !== scale(r)) begin
        n_fail++; $display("FAIL sat_rand res %h got %h want %h", r, out_data, scale(r));
      end
      drain();
    end
  endtask

  task automatic test_fill_overflow();
    logic [WO-1:0] exp_q[$];
    for (int i = 0; i <= 85; i++) begin
      start = (i < 85);
      res   = $urandom();
      if (i % 17 == 0 && i > 0) exp_q.push_back(scale(res));
      tick();
      n_cmp++;
      if (level !== 3'(m_q.size())) begin
        n_fail++; $display("FAIL fill_level edge %0d got %0d want %0d", i, level, m_q.size());
      end
    end
    start = 1'b0;
    n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL fill_ovf got %b want 1", overflow); end
    n_cmp++; if (level !== 3'd4) begin n_fail++; $display("FAIL fill_full got %0d want 4", level); end
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL clear_ovf got %b want 0", overflow); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (out_data !== exp_q[i]) begin
        n_fail++; $display("FAIL fill_order %0d got %h want %h", i, out_data, exp_q[i]);
      end
      tick();
    end
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fill_empty valid got %b want 0", out_valid); end
  endtask

  task automatic test_full_pop_push();
    logic [WO-1:0] exp_q[$];
    for (int i = 0; i <= 85; i++) begin
      start     = (i < 85);
      out_ready = (i == 85);
      res       = $urandom();
      if (i % 17 == 0 && i > 0) exp_q.push_back(scale(res));
      tick();
    end
    start     = 1'b0;
    out_ready = 1'b0;
    void'(exp_q.pop_front());
    n_cmp++; if (level !== 3'd4) begin n_fail++; $display("FAIL poppush_level got %0d want 4", level); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL popush_ovf got %b want 0", overflow); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (out_data !== exp_q[i]) begin
        n_fail++; $display("FAIL popush_order %0d got %h want %h", i, out_data, exp_q[i]);
      end
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_enable_toggle();
    int en_edges;
    logic [WC-1:0] r;
    r      = $urandom();
    res    = r;
    enable = 1'b1;
    start  = 1'b1;
    tick();
    start    = 1'b0;
    en_edges = 0;
    for (int i = 0; i < 40; i++) begin
      enable = (i % 2 == 1);
      if (enable) en_edges++;
      tick();
      n_cmp++;
      if (level !== ((en_edges >= 17) ? 3'd1 : 3'd0)) begin
        n_fail++; $display("FAIL toggle_level clk %0d en_edges %0d got %0d", i, en_edges, level);
      end
    end
    n_cmp++; if (out_data !== scale(r)) begin n_fail++; $display("FAIL toggle_data got %h want %h", out_data, scale(r)); end
    enable    = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL toggle_pop_disabled valid got %b want 0", out_valid); end
    enable = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [WC-1:0] r;
    do_run($urandom());
    res   = $urandom();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    resetn = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got %b want 0", out_valid); end
    n_cmp++; if (level !== 3'd0) begin n_fail++; $display("FAIL rstmid_level got %0d want 0", level); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rstmid_ovf got %b want 0", overflow); end
    n_cmp++; if (out_data !== 16'h0000) begin n_fail++; $display("FAIL rstmid_data got %h want 0000", out_data); end
    tick();
    resetn = 1'b1;
    tick();
    repeat (20) tick();
    n_cmp++; if (level !== 3'd0) begin n_fail++; $display("FAIL rstmid_nopush got %0d want 0", level); end
    r     = $urandom();
    res   = r;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (16) tick();
    n_cmp++; if (level !== 3'd0) begin n_fail++; $display("FAIL rstmid_early got %0d want 0", level); end
    tick();
    n_cmp++; if (level !== 3'd1) begin n_fail++; $display("FAIL rstmid_capture got %0d want 1", level); end
    n_cmp++; if (out_data !== scale(r)) begin n_fail++; $display("FAIL rstmid_data2 got %h want %h", out_data, scale(r)); end
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      enable    = ($urandom_range(0, 9) < 8);
      start     = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 2);
      clear_ovf = ($urandom_range(0, 29) == 0);
      res       = $urandom();
      tick();
      n_cmp++;
      if (level !== 3'(m_q.size()) || out_valid !== (m_q.size() != 0) || overflow !== m_ovf) begin
        n_fail++;
        $display("FAIL rand_state cyc %0d level %0d/%0d valid %b ovf %b/%b", i, level, m_q.size(), out_valid, overflow, m_ovf);
      end
      if (m_q.size() != 0) begin
        n_cmp++;
        if (out_data !== m_q[0]) begin
          n_fail++; $display("FAIL rand_data cyc %0d got %h want %h", i, out_data, m_q[0]);
        end
      end
    end
    start     = 1'b0;
    out_ready = 1'b0;
    clear_ovf = 1'b0;
    enable    = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_saturation();
    test_fill_overflow();
    test_full_pop_push();
    test_enable_toggle();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mca_output_fifo.md
# mca_output_fifo

Downstream companion to the multi-cycle adder (`multi_clk_adder`) in the FIR estimator datapath. It sees the same `start`/`enable` the adder sees and tracks the adder's fixed 17-enabled-cycle schedule. When the adder's result register is valid, it captures `res`, scales it with an arithmetic shift and saturation, and pushes it into a small FIFO. A valid/ready output port then drains the estimates to the downstream consumer (decimator/readout).

## Interface
- `WIDTH_COEFFICIENT`, 32: width of `res` (matches the adder).
- `WIDTH_OUT`, 16: width of the output sample.
- `SHIFT`, 8: arithmetic right-shift applied before saturation; range 0..WIDTH_COEFFICIENT-1.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `ADD_CYCLES`, 16: adder ADDING-state length; fixed to the adder's internal addition count.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `resetn`  in  1  reset; asynchronous assert, active-low.
- `enable`  in  1  same enable the adder receives; gates the tracker and the capture.
- `start`  in  1  same start the adder receives.
- `res`  in  WIDTH_COEFFICIENT  signed adder result.
- `out_ready`  in  1  consumer accepts the head entry.
- `clear_ovf`  in  1  synchronous clear of `overflow`.
- `out_data`  out  WIDTH_OUT  signed FIFO head; reset 0.
- `out_valid`  out  1  FIFO non-empty; reset 0.
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy; reset 0.
- `overflow`  out  1  sticky flag: a capture was dropped; reset 0.

## Operation
**Tracker FSM (state and counter advance only when `enable`=1):**
- `T_IDLE`:
  - `start`=1 → `T_WAIT`, `cnt`=0.
- `T_WAIT`:
  - `cnt` increments each enabled edge; `start` is ignored here, as in the adder.
  - On the edge where `cnt`==ADD_CYCLES-1 → `T_CAPT`.
- `T_CAPT`:
  - `res` is valid in this state.
  - On the enabled edge the scaled `res` is pushed into the FIFO.
  - Next state is `T_WAIT` with `cnt`=0 if `start`=1, otherwise `T_IDLE`. This matches the adder sampling `start` in IDLE on the same edge.
- `enable`=0 freezes the tracker, including in `T_CAPT`, where the capture is deferred.
- `cnt` is 5 bits.

**Scaling:**
- `sh` = `res` >>> SHIFT (sign-extending; −1 stays −1).
- If `sh` > 2^(WIDTH_OUT−1)−1 → max positive.
- If `sh` < −2^(WIDTH_OUT−1) → min negative.
- Otherwise `out` = `sh` truncated to WIDTH_OUT.

**FIFO:**
- Circular buffer with read/write pointers and `level`.
- Pop occurs when `out_valid`&&`out_ready`; the pop side is not gated by `enable`.
- Push when not full: entry is written.
- Push when full with a pop in the same cycle: accepted, `level` unchanged.
- Push when full with no pop: sample dropped, `overflow`←1, FIFO contents untouched.
- `clear_ovf`=1 clears `overflow`, except when a drop occurs in the same cycle: the drop wins and `overflow` stays 1.
- Pointers wrap modulo DEPTH.
- `out_data` shows the head combinationally from storage. It is 0 when empty after reset; otherwise the stale content is don't-care while `out_valid`=0.

## Timing
- `start` sampled on enabled edge E0 → push occurs on edge E17. The entry is visible on `out_data` with `out_valid`=1 after E17.
- Back-to-back: `start` held high → one push every 17 enabled edges (E17, E34, …).
- `out_valid` rises the cycle after a push into an empty FIFO and falls after the pop of the last entry.
- Reset asserted mid-operation: tracker → `T_IDLE`, pointers and `level` → 0, `overflow` → 0, no push. An in-flight computation is abandoned; the adder resets identically.

## Test plan
- Single run, SHIFT=8, `res`=0x0000_1234 at E16..E17, `out_ready`=0 → push at E17, `out_data`=0x0012, `level`=1, `overflow`=0.
- Saturation and rounding:
  - `res`=0x7FFF_FFFF → 0x7FFF.
  - `res`=0x8000_0000 → 0x8000.
  - `res`=0xFFFF_FF00 → 0xFFFF.
  - `res`=0xFFFF_FFFF → 0xFFFF.
- `start` held high for 5 runs, `out_ready`=0, DEPTH=4 → pushes at E17/34/51/68 fill the FIFO. Fifth capture at E85 dropped, `overflow`=1, first four values intact. `clear_ovf` pulse → `overflow`=0.
- Full FIFO, `out_ready`=1 on the capture cycle → pop and push in the same cycle, `level` stays 4, no overflow, FIFO order preserved.
- `enable` toggled 1/0 every cycle during a run → push occurs on the 17th enabled edge after `start` (about 34 clocks); pops still proceed while `enable`=0.
- `resetn` low at cnt=9 → all outputs 0. New `start` after release → capture exactly 17 enabled edges later.
